// File: rtl/spw_mux_ctrl_pkg.sv
// SpW channel mux select sequencer: shared types and constants.
// FSM states, register addresses and status bit positions.
package spw_mux_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DISABLE,
        ST_GUARD,
        ST_SWITCH,
        ST_ENABLE
    } state_e;

    localparam logic [1:0] ADDR_TARGET = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_GUARD  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_TERR = 2;
    localparam int STAT_REJ  = 3;
    localparam int STAT_SEL  = 4;

endpackage

// File: rtl/spw_mux_ctrl_regs.sv
// SpW mux sequencer register file: Avalon decode, sticky status,
// W1C handling, irq register and combinational read mux.
module spw_mux_ctrl_regs
    import spw_mux_ctrl_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int RESET_SEL = 3,
    parameter int GUARD_RST = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic             busy,
    input  logic [SEL_W-1:0] mux_sel,
    input  logic             set_done,
    input  logic             set_terr,
    output logic [SEL_W-1:0] target,
    output logic [15:0]      guard,
    output logic             start,
    output logic             irq
);

    logic             wr_en;
    logic             wr_tgt;
    logic             clr;
    logic             busy_any;
    logic             acc;
    logic             same;
    logic             start_q;
    logic             same_q;
    logic             done_q;
    logic             terr_q;
    logic             rej_q;
    logic             irq_en_q;
    logic             irq_q;
    logic [SEL_W-1:0] target_q;
    logic [15:0]      guard_q;
    logic             unused_wd;

    assign unused_wd = ^writedata[31:16];

    assign wr_en    = chipselect & ~write_n;
    assign wr_tgt   = wr_en & (address == ADDR_TARGET);
    assign clr      = wr_en & (address == ADDR_STATUS);
    // A request still pending for the FSM counts as busy.
    assign busy_any = busy | start_q;
    assign acc      = wr_tgt & ~busy_any;
    assign same     = acc & (writedata[SEL_W-1:0] == mux_sel);

    // Configuration registers; target is frozen while a switch runs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= SEL_W'(RESET_SEL);
            guard_q  <= 16'(GUARD_RST);
            irq_en_q <= 1'b0;
        end else begin
            if (acc)
                target_q <= writedata[SEL_W-1:0];
            if (wr_en && address == ADDR_GUARD)
                guard_q <= writedata[15:0];
            if (wr_en && address == ADDR_CTRL)
                irq_en_q <= writedata[0];
        end
    end

    // Request pulses, sticky status bits (set beats clear) and irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q <= 1'b0;
            same_q  <= 1'b0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            rej_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            start_q <= acc & ~same;
            same_q  <= same;
            done_q  <= set_done | same_q |
                       (done_q & ~(clr & writedata[STAT_DONE]));
            terr_q  <= set_terr |
                       (terr_q & ~(clr & writedata[STAT_TERR]));
            rej_q   <= (wr_tgt & busy_any) |
                       (rej_q & ~(clr & writedata[STAT_REJ]));
            irq_q   <= irq_en_q & (done_q | terr_q | rej_q);
        end
    end

    // Read mux; unused bits read zero.
    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_TARGET: readdata[SEL_W-1:0] = target_q;
            ADDR_STATUS: begin
                readdata[STAT_BUSY]         = busy;
                readdata[STAT_DONE]         = done_q;
                readdata[STAT_TERR]         = terr_q;
                readdata[STAT_REJ]          = rej_q;
                readdata[STAT_SEL +: SEL_W] = mux_sel;
            end
            ADDR_GUARD:  readdata[15:0] = guard_q;
            ADDR_CTRL:   readdata[0]    = irq_en_q;
            default:     readdata       = '0;
        endcase
    end

    assign target = target_q;
    assign guard  = guard_q;
    assign start  = start_q;
    assign irq    = irq_q;

endmodule

// File: rtl/spw_mux_ch_select_ctrl.sv
// SpW channel mux select sequencer: disable link, wait idle, guard,
// switch select, re-enable link and wait for Run.
module spw_mux_ch_select_ctrl
    import spw_mux_ctrl_pkg::*;
#(
    parameter int SEL_W       = 2,
    parameter int RESET_SEL   = 3,
    parameter int GUARD_RST   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [SEL_W-1:0] mux_sel,
    output logic             link_enable,
    input  logic             link_idle,
    input  logic             link_running,
    output logic             irq
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_e           state_q;
    state_e           state_d;
    logic [15:0]      cnt_q;
    logic [15:0]      guard_lat_q;
    logic [SEL_W-1:0] mux_sel_q;
    logic             link_en_q;
    logic [SEL_W-1:0] target;
    logic [15:0]      guard;
    logic             start;
    logic             busy;
    logic             set_done;
    logic             set_terr;
    logic             to_last;
    logic             guard_last;
    logic             entering;

    spw_mux_ctrl_regs #(
        .SEL_W     (SEL_W),
        .RESET_SEL (RESET_SEL),
        .GUARD_RST (GUARD_RST)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy),
        .mux_sel    (mux_sel_q),
        .set_done   (set_done),
        .set_terr   (set_terr),
        .target     (target),
        .guard      (guard),
        .start      (start),
        .irq        (irq)
    );

    assign busy       = (state_q != ST_IDLE);
    assign to_last    = (cnt_q == TO_LAST);
    // guard of 0 still spends one cycle in GUARD.
    assign guard_last = (guard_lat_q == 16'd0) ||
                        (cnt_q == guard_lat_q - 16'd1);
    assign entering   = (state_d != state_q);

    // Next-state and status set pulses.
    always_comb begin
        state_d  = state_q;
        set_done = 1'b0;
        set_terr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_DISABLE;
            end
            ST_DISABLE: begin
                if (link_idle) begin
                    state_d = ST_GUARD;
                end else if (to_last) begin
                    set_terr = 1'b1;
                    state_d  = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (guard_last)
                    state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (link_running) begin
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end else if (to_last) begin
                    set_terr = 1'b1;
                    set_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, guard latch, select and link enable registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            guard_lat_q <= '0;
            mux_sel_q   <= SEL_W'(RESET_SEL);
            link_en_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (entering)
                cnt_q <= '0;
            else if (state_q != ST_IDLE)
                cnt_q <= cnt_q + 16'd1;
            if (entering && state_d == ST_GUARD)
                guard_lat_q <= guard;
            if (entering && state_d == ST_SWITCH)
                mux_sel_q <= target;
            if (entering && state_d == ST_DISABLE)
                link_en_q <= 1'b0;
            else if (entering && (state_d == ST_ENABLE ||
                                  state_d == ST_IDLE))
                link_en_q <= 1'b1;
        end
    end

    assign mux_sel     = mux_sel_q;
    assign link_enable = link_en_q;

endmodule

// File: tb/tb_spw_mux_ch_select_ctrl.sv
// Bench for the SpW mux select sequencer: register table, directed
// corner sequences and randomized switches against a timing model.
module tb_spw_mux_ch_select_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [1:0]  mux_sel;
    logic        link_enable;
    logic        link_idle;
    logic        link_running;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[10];

    spw_mux_ch_select_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .mux_sel      (mux_sel),
        .link_enable  (link_enable),
        .link_idle    (link_idle),
        .link_running (link_running),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        logic [1:0]  cur;

        vt[0] = '{0, 2'd0, 32'h0,        32'h3,    "rst_target"};
        vt[1] = '{0, 2'd1, 32'h0,        32'h30,   "rst_status"};
        vt[2] = '{0, 2'd2, 32'h0,        32'h10,   "rst_guard"};
        vt[3] = '{0, 2'd3, 32'h0,        32'h0,    "rst_ctrl"};
        vt[4] = '{1, 2'd2, 32'hFFFFABCD, 32'hABCD, "guard_mask"};
        vt[5] = '{1, 2'd3, 32'hFFFFFFFF, 32'h1,    "ctrl_set"};
        vt[6] = '{1, 2'd3, 32'hFFFFFFFE, 32'h0,    "ctrl_clr"};
        vt[7] = '{1, 2'd1, 32'hFFFFFFFF, 32'h30,   "status_ro"};
        vt[8] = '{1, 2'd2, 32'h00000007, 32'h7,    "guard_7"};
        vt[9] = '{1, 2'd2, 32'h00000000, 32'h0,    "guard_0"};

        reset_n      = 1'b0;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = '0;
        link_idle    = 1'b1;
        link_running = 1'b1;
        step(3);
        chk("rst_mux_sel", 32'(mux_sel), 32'd3);
        chk("rst_link_en", 32'(link_enable), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        reset_n = 1'b1;
        step(1);

        foreach (vt[i]) begin
            if (vt[i].is_wr)
                wr(vt[i].addr, vt[i].wdata);
            rd(vt[i].addr, st);
            chk(vt[i].name, st, vt[i].exp);
        end

        // Minimum-latency switch 3 -> 1
        wr(2'd0, 32'd1);
        chk("t1_le_N", 32'(link_enable), 32'd1);
        step(1);
        chk("t1_le_N1", 32'(link_enable), 32'd0);
        rd(2'd1, st);
        chk("t1_busy_N1", 32'(st[0]), 32'd1);
        step(1);
        chk("t1_le_N2", 32'(link_enable), 32'd0);
        chk("t1_mux_N2", 32'(mux_sel), 32'd3);
        step(1);
        chk("t1_le_N3", 32'(link_enable), 32'd0);
        chk("t1_mux_N3", 32'(mux_sel), 32'd1);
        step(1);
        chk("t1_le_N4", 32'(link_enable), 32'd1);
        rd(2'd1, st);
        chk("t1_stat_N4", st, 32'h11);
        step(1);
        rd(2'd1, st);
        chk("t1_stat_N5", st, 32'h12);
        wr(2'd1, 32'h2);
        rd(2'd1, st);
        chk("t1_w1c", st, 32'h10);

        // Same-value write: no sequence
        wr(2'd0, 32'd1);
        rd(2'd1, st);
        chk("t2_stat_N", st, 32'h10);
        step(1);
        rd(2'd1, st);
        chk("t2_stat_N1", st, 32'h12);
        chk("t2_le_N1", 32'(link_enable), 32'd1);
        step(3);
        rd(2'd1, st);
        chk("t2_stat_N4", st, 32'h12);
        chk("t2_le_N4", 32'(link_enable), 32'd1);
        wr(2'd1, 32'h2);

        // Disable timeout, guard 5, reject while busy, irq and W1C
        wr(2'd2, 32'd5);
        wr(2'd3, 32'd1);
        link_idle    = 1'b0;
        link_running = 1'b1;
        wr(2'd0, 32'd0);
        step(3);
        wr(2'd0, 32'd2);
        rd(2'd1, st);
        chk("t3_reject", 32'(st[3]), 32'd1);
        rd(2'd0, st);
        chk("t3_target_kept", st, 32'd0);
        chk("t3_irq_N4", 32'(irq), 32'd0);
        step(1);
        chk("t3_irq_N5", 32'(irq), 32'd1);
        step(1019);
        rd(2'd1, st);
        chk("t3_terr_N1024", 32'(st[2]), 32'd0);
        chk("t3_le_N1024", 32'(link_enable), 32'd0);
        step(1);
        rd(2'd1, st);
        chk("t3_terr_N1025", 32'(st[2]), 32'd1);
        step(4);
        chk("t3_mux_N1029", 32'(mux_sel), 32'd1);
        step(1);
        chk("t3_mux_N1030", 32'(mux_sel), 32'd0);
        chk("t3_le_N1030", 32'(link_enable), 32'd0);
        step(1);
        chk("t3_le_N1031", 32'(link_enable), 32'd1);
        step(1);
        rd(2'd1, st);
        chk("t3_stat_done", st, 32'h0E);
        chk("t3_irq_done", 32'(irq), 32'd1);
        wr(2'd1, 32'h0E);
        rd(2'd1, st);
        chk("t3_w1c", st, 32'h00);
        chk("t3_irq_M", 32'(irq), 32'd1);
        step(1);
        chk("t3_irq_M1", 32'(irq), 32'd0);

        // Asynchronous reset in the middle of GUARD
        wr(2'd3, 32'd0);
        wr(2'd2, 32'd20);
        link_idle = 1'b1;
        wr(2'd0, 32'd2);
        step(3);
        chk("t4_mux_pre", 32'(mux_sel), 32'd0);
        chk("t4_le_pre", 32'(link_enable), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t4_mux_rst", 32'(mux_sel), 32'd3);
        chk("t4_le_rst", 32'(link_enable), 32'd1);
        rd(2'd1, st);
        chk("t4_stat_rst", st, 32'h30);
        reset_n = 1'b1;
        step(1);

        // Randomized switches against a timing model
        cur = 2'd3;
        for (int n = 0; n < 30; n++) begin
            int t, g, d, e, ie, s_rel, d_rel;
            bit same;
            t  = $urandom_range(0, 3);
            g  = $urandom_range(0, 6);
            d  = $urandom_range(0, 5);
            e  = $urandom_range(0, 4);
            ie = $urandom_range(0, 1);
            wr(2'd1, 32'hE);
            wr(2'd2, 32'(g));
            wr(2'd3, 32'(ie));
            link_idle    = 1'b0;
            link_running = 1'b0;
            step(2);
            same  = (t == int'(cur));
            s_rel = 2 + d + ((g == 0) ? 1 : g);
            d_rel = same ? 1 : s_rel + 2 + e;
            wr(2'd0, 32'(t));
            for (int r = 1; r <= d_rel + 1; r++) begin
                logic [1:0] m_exp;
                logic       le_exp;
                step(1);
                if (!same && r == 1 + d)
                    link_idle = 1'b1;
                if (!same && r == s_rel + 1 + e)
                    link_running = 1'b1;
                m_exp  = (!same && r >= s_rel) ? 2'(t) : cur;
                le_exp = !(!same && r <= s_rel);
                rd(2'd1, st);
                chk("rnd_mux", 32'(mux_sel), 32'(m_exp));
                chk("rnd_le", 32'(link_enable), 32'(le_exp));
                chk("rnd_busy", 32'(st[0]),
                    32'(!same && r < d_rel));
                chk("rnd_done", 32'(st[1]), 32'(r >= d_rel));
                chk("rnd_irq", 32'(irq),
                    32'(ie == 1 && r >= d_rel + 1));
            end
            cur = 2'(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
